// File: rtl/programmable_blinker.sv
// Square-wave blinker with a saturating speed index.
// Shift inputs are edge-detected; an effective step restarts the half-period.
module programmable_blinker #(
    parameter int CNT_W       = 24,
    parameter int SPD_W       = 2,
    parameter int NUM_SPEEDS  = 4,
    parameter int BASE_HALF   = 4,
    parameter int RESET_SPEED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic             blink_out,
    output logic [SPD_W-1:0] speed,
    output logic             toggle
);
    localparam logic [SPD_W-1:0] MAX_SPD = SPD_W'(NUM_SPEEDS - 1);
    localparam logic [SPD_W-1:0] RST_SPD = SPD_W'(RESET_SPEED);
    localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_HALF);

    logic [SPD_W-1:0] speed_q, speed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic             toggle_q, toggle_d;
    logic             left_q, right_q;

    logic             left_edge, right_edge;
    logic             step_up, step_dn;
    logic [SPD_W-1:0] shamt;
    logic [CNT_W-1:0] half_m1;

    assign left_edge  = shift_left & ~left_q;
    assign right_edge = shift_right & ~right_q;
    // Simultaneous edges cancel; steps at a limit saturate silently.
    assign step_up    = right_edge & ~left_edge & (speed_q < MAX_SPD);
    assign step_dn    = left_edge & ~right_edge & (speed_q != '0);

    assign shamt   = MAX_SPD - speed_q;
    assign half_m1 = (BASE << shamt) - CNT_W'(1);

    always_comb begin
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        blink_d  = blink_q;
        toggle_d = 1'b0;
        if (step_up) begin
            speed_d = speed_q + SPD_W'(1);
        end else if (step_dn) begin
            speed_d = speed_q - SPD_W'(1);
        end
        // A speed change restarts the period and swallows any coincident tick.
        if (step_up || step_dn) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == half_m1) begin
                cnt_d    = '0;
                blink_d  = ~blink_q;
                toggle_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_q  <= RST_SPD;
            cnt_q    <= '0;
            blink_q  <= 1'b0;
            toggle_q <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            toggle_q <= toggle_d;
            left_q   <= shift_left;
            right_q  <= shift_right;
        end
    end

    assign blink_out = blink_q;
    assign speed     = speed_q;
    assign toggle    = toggle_q;
endmodule

// File: tb/tb_programmable_blinker.sv
// Directed bench for programmable_blinker: vector table plus
// hand-written multi-cycle sequences for period and collision cases.
module tb_programmable_blinker;
    logic       clk = 1'b0;
    logic       reset, tick, shift_left, shift_right;
    logic       blink_out, toggle;
    logic [1:0] speed;

    int tests = 0;
    int fails = 0;

    programmable_blinker dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .shift_left (shift_left),
        .shift_right(shift_right),
        .blink_out  (blink_out),
        .speed      (speed),
        .toggle     (toggle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       t;
        logic       l;
        logic       r;
        logic       b;
        logic [1:0] s;
        logic       tg;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t v(input logic rst, t, l, r, b,
                               input logic [1:0] s, input logic tg);
        vec_t x;
        x.rst = rst; x.t = t; x.l = l; x.r = r;
        x.b = b; x.s = s; x.tg = tg;
        return x;
    endfunction

    task automatic cyc(input logic rst, t, l, r);
        reset = rst; tick = t; shift_left = l; shift_right = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic b,
                           input logic [1:0] s, input logic tg);
        chk({name, " blink"}, int'(blink_out), int'(b));
        chk({name, " speed"}, int'(speed), int'(s));
        chk({name, " toggle"}, int'(toggle), int'(tg));
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; shift_left = 1'b0; shift_right = 1'b0;

        //          rst t  l  r  | b  s  tg
        tbl[0]  = v(1, 0, 0, 0, 0, 1, 0);
        tbl[1]  = v(1, 1, 0, 0, 0, 1, 0);
        tbl[2]  = v(0, 1, 0, 1, 0, 2, 0);
        tbl[3]  = v(0, 1, 0, 0, 0, 2, 0);
        tbl[4]  = v(0, 0, 0, 1, 0, 3, 0);
        tbl[5]  = v(0, 1, 0, 0, 0, 3, 0);
        tbl[6]  = v(0, 1, 0, 0, 0, 3, 0);
        tbl[7]  = v(0, 1, 0, 0, 0, 3, 0);
        tbl[8]  = v(0, 1, 0, 0, 1, 3, 1);
        tbl[9]  = v(0, 0, 0, 0, 1, 3, 0);
        tbl[10] = v(0, 1, 0, 1, 1, 3, 0);
        tbl[11] = v(0, 1, 0, 1, 1, 3, 0);
        tbl[12] = v(0, 1, 0, 0, 1, 3, 0);
        tbl[13] = v(0, 1, 0, 0, 0, 3, 1);
        tbl[14] = v(0, 1, 1, 1, 0, 3, 0);
        tbl[15] = v(0, 1, 0, 0, 0, 3, 0);
        tbl[16] = v(0, 1, 0, 0, 0, 3, 0);
        tbl[17] = v(0, 1, 1, 0, 0, 2, 0);
        tbl[18] = v(0, 1, 1, 0, 0, 2, 0);
        tbl[19] = v(0, 1, 0, 0, 0, 2, 0);
        tbl[20] = v(0, 1, 0, 0, 0, 2, 0);
        tbl[21] = v(0, 1, 0, 0, 0, 2, 0);
        tbl[22] = v(0, 1, 0, 0, 0, 2, 0);
        tbl[23] = v(0, 1, 0, 0, 0, 2, 0);
        tbl[24] = v(0, 1, 0, 0, 0, 2, 0);
        tbl[25] = v(0, 1, 0, 0, 1, 2, 1);
        tbl[26] = v(0, 1, 0, 0, 1, 2, 0);
        tbl[27] = v(0, 1, 0, 0, 1, 2, 0);
        tbl[28] = v(1, 1, 0, 0, 0, 1, 0);
        tbl[29] = v(0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            cyc(tbl[i].rst, tbl[i].t, tbl[i].l, tbl[i].r);
            chk_out($sformatf("vec%0d", i), tbl[i].b, tbl[i].s, tbl[i].tg);
        end

        // Default period after reset: edges at tick 16 and 32.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_out("dflt reset", 0, 1, 0);
        for (int n = 1; n <= 32; n++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("dflt blink n%0d", n), int'(blink_out), (n / 16) % 2);
            chk($sformatf("dflt toggle n%0d", n), int'(toggle),
                (n % 16 == 0) ? 1 : 0);
        end

        // Slow-down limit with blink held high across steps.
        cyc(1, 0, 0, 0);
        for (int n = 0; n < 16; n++) cyc(0, 1, 0, 0);
        chk("lim pre blink", int'(blink_out), 1);
        for (int p = 0; p < 5; p++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("lim speed p%0d", p), int'(speed), 0);
            chk($sformatf("lim blink p%0d", p), int'(blink_out), 1);
            cyc(0, 0, 0, 0);
        end
        for (int n = 1; n <= 32; n++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("lim blink n%0d", n), int'(blink_out),
                (n == 32) ? 0 : 1);
        end

        // Right edge on the tick that would wrap: no toggle, new period.
        cyc(1, 0, 0, 0);
        for (int n = 0; n < 15; n++) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        chk_out("coll", 0, 2, 0);
        for (int n = 1; n <= 8; n++) begin
            cyc(0, 1, 0, (n == 1) ? 1'b1 : 1'b0);
            chk($sformatf("coll blink n%0d", n), int'(blink_out),
                (n == 8) ? 1 : 0);
            chk($sformatf("coll speed n%0d", n), int'(speed), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
